z80_bus_tracer: RTL

Passive bus-trace capture stage directly downstream of the z80 core's external bus. Snoops A, nRD, nWR, READ_D and WRITE_D, and records each distinct memory access as one entry in an internal FIFO. An optional address trigger gates when capture starts. A host-side consumer drains entries through a valid/ready handshake; the block never drives or stalls the core bus.

---
 rtl/z80_bus_tracer.sv | 104 ++++++++++
 1 files changed

// File: rtl/z80_bus_tracer.sv
// Passive Z80 bus-trace capture. Each distinct memory access is recorded in
// a first-word-fall-through FIFO. An optional address trigger delays the
// start of capture. The core bus is never driven or stalled.
module z80_bus_tracer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nRD,
  input  logic             nWR,
  input  logic [15:0]      A,
  input  logic [7:0]       READ_D,
  input  logic [7:0]       WRITE_D,
  input  logic             enable,
  input  logic             trig_en,
  input  logic [15:0]      trig_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [25:0]      out_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic [7:0]       overflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {DISARMED, ARMED} arm_t;

  arm_t             arm_state, arm_next;
  logic [1:0]       kind, prev_kind;
  logic [15:0]      prev_a;
  logic [7:0]       entry_data;
  logic             qualifying, trig_hit, push, do_pop, do_write;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [25:0]      mem [DEPTH];

  // Decode the access kind and decide whether this cycle starts a new access
  always_comb begin
    kind       = {~nWR, ~nRD};
    entry_data = (kind == 2'b01) ? READ_D : WRITE_D;
    qualifying = (kind != 2'b00) &&
                 ((prev_kind == 2'b00) || (kind != prev_kind) || (A != prev_a));
    trig_hit   = qualifying && trig_en && (A == trig_addr);
  end

  // Previous-access register tracks the bus every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_kind <= 2'b00;
      prev_a    <= '0;
    end else begin
      prev_kind <= kind;
      prev_a    <= A;
    end
  end

  // Arm state register
  always_ff @(posedge clk) begin
    if (reset) arm_state <= DISARMED;
    else       arm_state <= arm_next;
  end

  // Arm next-state: the triggering access itself is captured via trig_hit
  always_comb begin
    arm_next = arm_state;
    if (!enable)                  arm_next = DISARMED;
    else if (!trig_en || trig_hit) arm_next = ARMED;
  end

  // FIFO control: a push into a full FIFO only lands if a pop frees a slot
  always_comb begin
    push      = qualifying && enable && ((arm_state == ARMED) || trig_hit);
    out_valid = (count != '0);
    full      = (count == FULL_CNT);
    do_pop    = out_valid && out_ready;
    do_write  = push && (!full || do_pop);
    out_data  = mem[rd_ptr];
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= {kind, A, entry_data};
  end

  // Pointers, occupancy and overflow counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_write && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_write && do_pop) count <= count - CNT_W'(1);
      if (push && !do_write && overflow_cnt != 8'hFF)
        overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

endmodule
